// File: rtl/kyber_noise_loader_if.sv
// kyber_noise_loader_if: 32-bit write bus into the Baby Kyber accelerator register window
interface kyber_noise_loader_if;
    logic        wen_Req;
    logic [31:0] addr_Req;
    logic [31:0] data_Req;
    logic [7:0]  bytelane_Req;
    modport master(output wen_Req, addr_Req, data_Req, bytelane_Req);
    modport slave(input wen_Req, addr_Req, data_Req, bytelane_Req);
endinterface

// File: rtl/kyber_noise_loader.sv
// kyber_noise_loader: expands a seed via LFSR into Kyber keygen/encrypt inputs and writes them to the accelerator
module kyber_noise_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h40007000,
    parameter logic [31:0] POLY      = 32'h80200003
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [1:0]                   op,
    input  logic [31:0]                  seed,
    input  logic [31:0]                  message,
    output logic                         enable,
    output logic                         busy,
    output logic                         done,
    kyber_noise_loader_if.master         bus
);
    typedef enum logic [3:0] {
        IDLE, GEN_A, GEN_S, GEN_E, TRIG_KG, MSG, GEN_R, GEN_E1, GEN_E2, TRIG_ENC, DONE
    } state_t;

    state_t      state, state_n;
    logic [4:0]  idx, idx_n;
    logic [31:0] l, msg_q, wd, cbd;
    logic [1:0]  op_q;
    logic [11:0] base;
    logic        w, uni;

    assign uni = l[4:0] < 5'd17;
    // -1/0/+1 from l[0]-l[1], sign-extended to 32 bits
    assign cbd = {{31{~l[0] & l[1]}}, l[0] ^ l[1]};

    always_comb begin
        state_n = state;
        w = 1'b0;
        base = 12'h000;
        wd = 32'h0;
        case (state)
            IDLE:     if (start) state_n = op[0] ? GEN_A : (op[1] ? MSG : DONE);
            GEN_A: begin
                w = uni;
                wd = {27'd0, l[4:0]};
                if (uni && idx == 5'd15) state_n = GEN_S;
            end
            GEN_S: begin
                w = 1'b1; base = 12'h040; wd = cbd;
                if (idx == 5'd7) state_n = GEN_E;
            end
            GEN_E: begin
                w = 1'b1; base = 12'h060; wd = cbd;
                if (idx == 5'd7) state_n = TRIG_KG;
            end
            TRIG_KG: begin
                w = 1'b1; base = 12'h164;
                state_n = op_q[1] ? MSG : DONE;
            end
            MSG: begin
                w = 1'b1; base = 12'h080; wd = msg_q;
                state_n = GEN_R;
            end
            GEN_R: begin
                w = 1'b1; base = 12'h084; wd = cbd;
                if (idx == 5'd7) state_n = GEN_E1;
            end
            GEN_E1: begin
                w = 1'b1; base = 12'h0A4; wd = cbd;
                if (idx == 5'd7) state_n = GEN_E2;
            end
            GEN_E2: begin
                w = 1'b1; base = 12'h0C4; wd = cbd;
                if (idx == 5'd3) state_n = TRIG_ENC;
            end
            TRIG_ENC: begin
                w = 1'b1; base = 12'h168;
                state_n = DONE;
            end
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // single-write states enter with idx=0, so base+4*idx covers every state
    assign idx_n = (state_n != state) ? 5'd0 : idx + {4'd0, w};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= 5'd0;
            l <= 32'h1;
            op_q <= 2'b00;
            msg_q <= 32'h0;
            enable <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            bus.wen_Req <= 1'b0;
            bus.addr_Req <= 32'h0;
            bus.data_Req <= 32'h0;
            bus.bytelane_Req <= 8'h00;
        end else begin
            state <= state_n;
            idx <= idx_n;
            if (state == IDLE) begin
                if (start) begin
                    l <= (seed == 32'h0) ? 32'h1 : seed;
                    op_q <= op;
                    msg_q <= message;
                end
            end else begin
                l <= (l >> 1) ^ (l[0] ? POLY : 32'h0);
            end
            busy <= state != IDLE;
            enable <= state != IDLE;
            done <= state == DONE;
            bus.wen_Req <= w;
            bus.bytelane_Req <= w ? 8'hFF : 8'h00;
            if (w) begin
                bus.addr_Req <= BASE_ADDR + {20'd0, base + {5'd0, idx, 2'b00}};
                bus.data_Req <= wd;
            end
        end
    end
endmodule

// File: tb/tb_kyber_noise_loader.sv
// tb_kyber_noise_loader: table-driven and randomized checks against a write-stream model of the loader
module tb_kyber_noise_loader;
    localparam logic [31:0] BASE = 32'h40007000;
    localparam logic [31:0] POLY = 32'h80200003;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [31:0] seed = 32'h0, message = 32'h0;
    logic enable, busy, done;
    int n_cmp = 0, n_bad = 0;

    kyber_noise_loader_if bus();
    kyber_noise_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .seed(seed), .message(message),
        .enable(enable), .busy(busy), .done(done), .bus(bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to have finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // reference: the full write stream as a list of (address, data) plus busy-cycle count
    logic [31:0] exp_a[$], exp_d[$], got_a[$], got_d[$];
    logic [31:0] ml;
    int exp_cyc;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? POLY : 32'h0);
    endfunction

    function automatic void put(input int off, input logic [31:0] d);
        exp_a.push_back(BASE + 32'(off));
        exp_d.push_back(d);
        ml = lfsr_next(ml);
        exp_cyc++;
    endfunction

    function automatic logic [31:0] cbd_val(input logic [31:0] x);
        int c;
        c = int'(x[0]) - int'(x[1]);
        return 32'(c);
    endfunction

    task automatic model(input logic [1:0] o, input logic [31:0] s, input logic [31:0] m);
        exp_a.delete();
        exp_d.delete();
        ml = (s == 32'h0) ? 32'h1 : s;
        exp_cyc = 1;
        if (o[0]) begin
            for (int k = 0; k < 16; k++) begin
                while (ml % 32 >= 17) begin
                    ml = lfsr_next(ml);
                    exp_cyc++;
                end
                put(4 * k, ml % 32);
            end
            for (int k = 0; k < 16; k++) put('h40 + 4 * k, cbd_val(ml));
            put('h164, 32'h0);
        end
        if (o[1]) begin
            put('h80, m);
            for (int k = 0; k < 20; k++) put('h84 + 4 * k, cbd_val(ml));
            put('h168, 32'h0);
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] s, input logic [31:0] m, input logic mid);
        int bc, dc, fb, bad_sig, n;
        model(o, s, m);
        got_a.delete();
        got_d.delete();
        @(negedge clk);
        start = 1'b1; op = o; seed = s; message = m;
        @(negedge clk);
        start = 1'b0;
        bc = 0; dc = 0; fb = -1; bad_sig = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (mid && c == 5) begin
                start = 1'b1; op = 2'b10; seed = 32'h1234; message = 32'hFFFF;
            end
            if (mid && c == 6) start = 1'b0;
            if (busy) begin
                bc++;
                if (fb < 0) fb = c;
            end
            if (bus.wen_Req) begin
                got_a.push_back(bus.addr_Req);
                got_d.push_back(bus.data_Req);
            end
            if (bus.bytelane_Req !== (bus.wen_Req ? 8'hFF : 8'h00)) bad_sig++;
            if (enable !== busy) bad_sig++;
            if (done) dc++;
            if (bc > 0 && !busy) break;
        end
        check("busy_ended", 32'(busy), 32'h0);
        check("first_busy_cycle", 32'(fb), 32'h0);
        check("busy_cycles", 32'(bc), 32'(exp_cyc));
        check("done_pulses", 32'(dc), 32'h1);
        check("bytelane_enable", 32'(bad_sig), 32'h0);
        check("write_count", 32'(got_a.size()), 32'(exp_a.size()));
        n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("addr[%0d]", i), got_a[i], exp_a[i]);
            check($sformatf("data[%0d]", i), got_d[i], exp_d[i]);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] seed;
        logic [31:0] msg;
        logic        mid;
        int          n_wr;
        logic [31:0] first_a;
        logic [31:0] last_a;
    } vec_t;

    vec_t tv[5];

    initial begin
        int cnt, hits;
        logic seen;
        tv[0] = '{2'b01, 32'h1,        32'h0,        1'b0, -1, 32'h40007000, 32'h40007164};
        tv[1] = '{2'b10, 32'h9,        32'h5,        1'b0, 22, 32'h40007080, 32'h40007168};
        tv[2] = '{2'b11, 32'hDEADBEEF, 32'h12345678, 1'b0, -1, 32'h40007000, 32'h40007168};
        tv[3] = '{2'b01, 32'h0,        32'h0,        1'b1, -1, 32'h40007000, 32'h40007164};
        tv[4] = '{2'b00, 32'h7,        32'h3,        1'b0, 0,  32'h0,        32'h0};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_enable", 32'(enable), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_wen", 32'(bus.wen_Req), 32'h0);
        check("rst_addr", bus.addr_Req, 32'h0);
        check("rst_data", bus.data_Req, 32'h0);
        check("rst_bytelane", 32'(bus.bytelane_Req), 32'h0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || enable || done || bus.wen_Req) cnt++;
        end
        check("idle_activity", 32'(cnt), 32'h0);

        for (int i = 0; i < 5; i++) begin
            run(tv[i].op, tv[i].seed, tv[i].msg, tv[i].mid);
            if (tv[i].n_wr >= 0) check($sformatf("vec%0d_writes", i), 32'(got_a.size()), 32'(tv[i].n_wr));
            if (got_a.size() > 0) begin
                check($sformatf("vec%0d_first_addr", i), got_a[0], tv[i].first_a);
                check($sformatf("vec%0d_last_addr", i), got_a[got_a.size() - 1], tv[i].last_a);
            end
        end

        // first sample 0x1F is rejected; next LFSR state gives 12 for A[0][0]
        @(negedge clk);
        start = 1'b1; op = 2'b01; seed = 32'h0000001F;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rej_busy", 32'(busy), 32'h1);
        check("rej_wen", 32'(bus.wen_Req), 32'h0);
        @(negedge clk);
        check("rej_next_wen", 32'(bus.wen_Req), 32'h1);
        check("rej_next_addr", bus.addr_Req, 32'h40007000);
        check("rej_next_data", bus.data_Req, 32'd12);
        cnt = 0;
        while (busy && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("rej_run_end", 32'(busy), 32'h0);

        for (int i = 0; i < 6; i++)
            run(2'($urandom_range(1, 3)), $urandom, $urandom, 1'b0);

        // reset in the middle of GEN_R
        @(negedge clk);
        start = 1'b1; op = 2'b11; seed = $urandom; message = 32'hA5A5A5A5;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (bus.wen_Req && bus.addr_Req >= 32'h40007084 && bus.addr_Req <= 32'h400070A0) seen = 1'b1;
        end
        check("reach_gen_r", 32'(seen), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_outputs", 32'(|{busy, enable, done, bus.wen_Req, bus.bytelane_Req, bus.addr_Req, bus.data_Req}), 32'h0);
        rst_n = 1'b1;
        hits = 0;
        repeat (100) begin
            @(negedge clk);
            if (done || busy || (bus.wen_Req && bus.addr_Req == 32'h40007168)) hits++;
        end
        check("midrst_no_trigger", 32'(hits), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
